// File: rtl/cam_i2c_write_master.sv
// cam_i2c_write_master
// Serialises one camera register write (slave address, 16-bit register
// address, 8-bit data) as a single I2C write frame on open-drain SCL/SDA.
//
// Ports:
//   clk400       block clock, all logic on posedge
//   reset        synchronous, active-high reset
//   send_data    request strobe, sampled only while idle
//   slave_addr   [6:0] 7-bit I2C address, [7] ignored
//   register_in  register address, MSB byte sent first
//   datain       data byte
//   ready        1 = idle and able to accept a request
//   nack_err     sticky NACK flag for the last frame
//   scl, sda     open-drain lines: driven 0 or Z, never 1
//
// Handshake: a request is taken on any clock edge where ready=1 and
// send_data=1. The operands are captured on that edge, and ready drops
// right after it. ready returns high only when the frame and the
// bus-free gap are finished. A send_data seen while ready=0 is dropped,
// not queued.
//
// Optional build macro: CAM_I2C_CLKSTRETCH_EN. When defined, the quarter
// counter stalls in the high-clock quarter (Q2) of BIT and STOP while
// the scl pin reads 0, so a slave can stretch the clock. There is no
// timeout. When undefined, the scl pin is never read.
//
// The FSM state is held in state_q (IDLE/START/BIT/STOP/FREE).
module cam_i2c_write_master #(
  parameter int QUARTER_DIV = 1,
  parameter int BUS_FREE    = 8
) (
  input  logic        clk400,
  input  logic        reset,
  input  logic        send_data,
  input  logic [7:0]  slave_addr,
  input  logic [15:0] register_in,
  input  logic [7:0]  datain,
  output logic        ready,
  output logic        nack_err,
  inout  wire         scl,
  inout  wire         sda
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_FREE  = 3'd4;

  localparam logic [7:0] DIV_LAST  = 8'(QUARTER_DIV - 1);
  localparam logic [7:0] FREE_LAST = 8'(BUS_FREE);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  free_q, free_d;
  logic [35:0] frame_q, frame_d;
  logic        nack_q, nack_d;

  logic        stretch;
  logic        ack_slot;
  logic        sda_in;
  logic        scl_low;
  logic        sda_low;
  logic        unused_addr_msb;

  assign unused_addr_msb = slave_addr[7];
  assign sda_in          = sda;

`ifdef CAM_I2C_CLKSTRETCH_EN
  assign stretch = ((state_q == S_BIT) || (state_q == S_STOP)) &&
                   (qtr_q == 2'd2) && (scl == 1'b0);
`else
  assign stretch = 1'b0;
`endif

  // The 9th bit of every byte is the slave's acknowledge slot.
  assign ack_slot = (bit_q == 6'd8) || (bit_q == 6'd17) ||
                    (bit_q == 6'd26) || (bit_q == 6'd35);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    free_d  = free_q;
    frame_d = frame_q;
    nack_d  = nack_q;
    case (state_q)
      S_IDLE: begin
        if (send_data) begin
          // ACK slots are stored as 1 so the master releases SDA there.
          frame_d = {slave_addr[6:0], 1'b0, 1'b1,
                     register_in[15:8], 1'b1,
                     register_in[7:0], 1'b1,
                     datain, 1'b1};
          nack_d  = 1'b0;
          div_d   = '0;
          qtr_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START, S_BIT, S_STOP: begin
        if (!stretch) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              if (state_q == S_START) begin
                bit_d   = '0;
                state_d = S_BIT;
              end else if (state_q == S_BIT) begin
                // SDA is sampled at the very end of Q3.
                if (ack_slot && sda_in) begin
                  nack_d  = 1'b1;
                  state_d = S_STOP;
                end else if (bit_q == 6'd35) begin
                  state_d = S_STOP;
                end else begin
                  bit_d = bit_q + 6'd1;
                end
              end else begin
                free_d  = '0;
                state_d = S_FREE;
              end
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      S_FREE: begin
        // Counts 0..BUS_FREE; the extra cycle lands ready on the
        // documented edge T + 152*QUARTER_DIV + BUS_FREE + 1.
        if (free_q == FREE_LAST) begin
          state_d = S_IDLE;
        end else begin
          free_d = free_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk400) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      free_q  <= '0;
      frame_q <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      free_q  <= free_d;
      frame_q <= frame_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_q)
      S_START: begin
        sda_low = (qtr_q != 2'd0);
        scl_low = (qtr_q == 2'd3);
      end
      S_BIT: begin
        scl_low = (qtr_q <= 2'd1);
        sda_low = ~frame_q[6'd35 - bit_q];
      end
      S_STOP: begin
        scl_low = (qtr_q == 2'd0);
        sda_low = (qtr_q != 2'd3);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
  end

  assign scl      = scl_low ? 1'b0 : 1'bz;
  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign ready    = (state_q == S_IDLE);
  assign nack_err = nack_q;

endmodule

// File: tb/tb_cam_i2c_write_master.sv
// Bench for cam_i2c_write_master: a default instance (QUARTER_DIV=1)
// and a QUARTER_DIV=4 instance. A bus monitor decodes START/STOP and the
// bits seen on SCL rising edges, and acts as the slave for ACK/NACK.
module tb_cam_i2c_write_master;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        send_a = 1'b0;
  logic        send_b = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  dat = 8'h00;
  logic [15:0] regv = 16'h0000;
  logic        ready_a, nack_a, ready_b, nack_b;

  wire scl_a, sda_a, scl_b, sda_b;
  pullup (scl_a);
  pullup (sda_a);
  pullup (scl_b);
  pullup (sda_b);

  logic slv_low = 1'b0;
  logic sel4 = 1'b0;
  logic str_low = 1'b0;
  int   nack_byte = 0;

  assign sda_a = (slv_low && !sel4) ? 1'b0 : 1'bz;
  assign sda_b = (slv_low && sel4) ? 1'b0 : 1'bz;
  assign scl_a = str_low ? 1'b0 : 1'bz;

  cam_i2c_write_master dut_a (
    .clk400(clk), .reset(rst), .send_data(send_a), .slave_addr(addr),
    .register_in(regv), .datain(dat), .ready(ready_a), .nack_err(nack_a),
    .scl(scl_a), .sda(sda_a)
  );

  cam_i2c_write_master #(.QUARTER_DIV(4), .BUS_FREE(8)) dut_b (
    .clk400(clk), .reset(rst), .send_data(send_b), .slave_addr(addr),
    .register_in(regv), .datain(dat), .ready(ready_b), .nack_err(nack_b),
    .scl(scl_b), .sda(sda_b)
  );

  int errors = 0;
  int checks = 0;

  // bus monitor + slave
  int   starts, stops, rises, falls;
  logic bits_q[$];
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;

  initial begin
    logic m_scl, m_sda;
    starts = 0; stops = 0; rises = 0; falls = 0;
    forever begin
      @(negedge clk);
      m_scl = sel4 ? scl_b : scl_a;
      m_sda = sel4 ? sda_b : sda_a;
      if (p_scl && m_scl && p_sda && !m_sda) begin
        starts++;
        falls = 0;
        bits_q.delete();
      end
      if (p_scl && m_scl && !p_sda && m_sda) begin
        stops++;
        // the STOP clock pulse is not a data bit
        if (bits_q.size() > 0) void'(bits_q.pop_back());
      end
      if (!p_scl && m_scl) begin
        rises++;
        bits_q.push_back(m_sda);
      end
      if (p_scl && !m_scl) begin
        falls++;
        if (falls % 9 == 0) slv_low = ((falls / 9) != nack_byte);
        else if (falls % 9 == 1) slv_low = 1'b0;
      end
      p_scl = m_scl;
      p_sda = m_sda;
    end
  end

  task automatic mon_clear();
    starts = 0; stops = 0; rises = 0; falls = 0;
    bits_q.delete();
    slv_low = 1'b0;
  endtask

  // observations
  int         obs_lat, obs_nbits;
  logic       obs_ready1, obs_nack1, obs_nack;
  logic [7:0] obs_bytes[$];
  logic       obs_acks[$];

  // scoreboard / reference model
  logic [7:0] exp_q[$];
  int         exp_lat;

  task automatic model(input bit use4, input logic [7:0] a, input logic [15:0] r,
                       input logic [7:0] d, input int nk, input int stretch_cyc);
    int nb, q;
    exp_q.delete();
    exp_q.push_back({a[6:0], 1'b0});
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(d);
    nb = (nk == 0) ? 4 : nk;
    while (exp_q.size() > nb) void'(exp_q.pop_back());
    q = use4 ? 4 : 1;
    // START + 9 bits per byte sent + STOP, four quarters each, then bus free
    exp_lat = (4 + 36 * nb + 4) * q + 8 + 1 + stretch_cyc;
  endtask

  // driver: issues one request and watches until ready returns
  task automatic do_frame(input bit use4, input logic [7:0] a, input logic [15:0] r,
                          input logic [7:0] d, input int nk, input int pulse_at,
                          input bit stretch);
    int n;
    logic rdy, nk_o, b;
    logic [7:0] byt;
    sel4 = use4;
    nack_byte = nk;
    mon_clear();
    addr = a; regv = r; dat = d;
    if (use4) send_b = 1'b1; else send_a = 1'b1;
    @(posedge clk);
    #1;
    send_a = 1'b0; send_b = 1'b0;
    obs_lat = -1; obs_ready1 = 1'b1; obs_nack1 = 1'b1; obs_nack = 1'b0;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (stretch && n == 49) str_low = 1'b1;
      if (stretch && n == 60) str_low = 1'b0;
      if (pulse_at != 0 && n == pulse_at) begin
        if (use4) send_b = 1'b1; else send_a = 1'b1;
      end
      if (pulse_at != 0 && n == pulse_at + 1) begin
        send_a = 1'b0; send_b = 1'b0;
      end
      rdy  = use4 ? ready_b : ready_a;
      nk_o = use4 ? nack_b : nack_a;
      if (n == 1) begin
        obs_ready1 = rdy;
        obs_nack1  = nk_o;
      end
      if (rdy) begin
        obs_lat = n;
        break;
      end
    end
    str_low = 1'b0;
    obs_nack = use4 ? nack_b : nack_a;
    obs_nbits = bits_q.size();
    obs_bytes.delete();
    obs_acks.delete();
    for (int i = 0; i + 9 <= bits_q.size(); i += 9) begin
      for (int k = 0; k < 8; k++) begin
        b = bits_q[i + k];
        byt[7 - k] = b;
      end
      obs_bytes.push_back(byt);
      obs_acks.push_back(bits_q[i + 8]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b expected 1/1", ready_a, ready_b);
    end
    checks++;
    if (nack_a !== 1'b0 || nack_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_nack: got %b/%b expected 0/0", nack_a, nack_b);
    end
    checks++;
    if (scl_a !== 1'b1 || sda_a !== 1'b1 || scl_b !== 1'b1 || sda_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_lines: got %b%b%b%b expected 1111", scl_a, sda_a, scl_b, sda_b);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_write();
    do_frame(1'b0, 8'h10, 16'h0100, 8'h01, 0, 0, 1'b0);
    model(1'b0, 8'h10, 16'h0100, 8'h01, 0, 0);
    checks++;
    if (obs_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_low: got %b expected 0", obs_ready1);
    end
    checks++;
    if (obs_lat != exp_lat) begin
      errors++;
      $display("FAIL full_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    checks++;
    if (starts != 1 || stops != 1 || rises != 37) begin
      errors++;
      $display("FAIL full_framing: got start=%0d stop=%0d rises=%0d expected 1 1 37",
               starts, stops, rises);
    end
    checks++;
    if (obs_nack !== 1'b0) begin
      errors++;
      $display("FAIL full_nack: got %b expected 0", obs_nack);
    end
    checks++;
    if (obs_bytes.size() != exp_q.size() || obs_nbits != 36) begin
      errors++;
      $display("FAIL full_nbytes: got %0d bits expected 36", obs_nbits);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_bytes[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL full_byte%0d: got %h expected %h", i, obs_bytes[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_nack_addr();
    do_frame(1'b0, 8'h10, 16'h0100, 8'h01, 1, 0, 1'b0);
    model(1'b0, 8'h10, 16'h0100, 8'h01, 1, 0);
    checks++;
    if (obs_lat != exp_lat) begin
      errors++;
      $display("FAIL nack_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    checks++;
    if (obs_nack !== 1'b1) begin
      errors++;
      $display("FAIL nack_flag: got %b expected 1", obs_nack);
    end
    checks++;
    if (starts != 1 || stops != 1 || rises != 10) begin
      errors++;
      $display("FAIL nack_framing: got start=%0d stop=%0d rises=%0d expected 1 1 10",
               starts, stops, rises);
    end
    checks++;
    if (obs_bytes.size() != 1 || obs_bytes[0] !== exp_q[0] || obs_acks[0] !== 1'b1) begin
      errors++;
      $display("FAIL nack_byte: got %0d bytes expected 1 byte %h with NACK",
               obs_bytes.size(), exp_q[0]);
    end
    // nack_err must stay valid through idle
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (nack_a !== 1'b1) begin
      errors++;
      $display("FAIL nack_sticky: got %b expected 1", nack_a);
    end
  endtask

  task automatic test_busy_ignore();
    do_frame(1'b0, 8'h10, 16'h0100, 8'h01, 0, 20, 1'b0);
    model(1'b0, 8'h10, 16'h0100, 8'h01, 0, 0);
    checks++;
    if (obs_nack1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_nack_clear: got %b expected 0", obs_nack1);
    end
    checks++;
    if (obs_lat != exp_lat || starts != 1 || stops != 1) begin
      errors++;
      $display("FAIL busy_single_frame: got lat=%0d start=%0d stop=%0d expected %0d 1 1",
               obs_lat, starts, stops, exp_lat);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ready_a !== 1'b1 || starts != 1) begin
      errors++;
      $display("FAIL busy_not_queued: got ready=%b starts=%0d expected 1 1", ready_a, starts);
    end
  endtask

  task automatic test_mid_reset();
    sel4 = 1'b0;
    nack_byte = 0;
    mon_clear();
    addr = 8'h10; regv = 16'h0100; dat = 8'h01;
    send_a = 1'b1;
    @(posedge clk);
    #1;
    send_a = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    rst = 1'b1;
    slv_low = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (scl_a !== 1'b1 || sda_a !== 1'b1) begin
      errors++;
      $display("FAIL midrst_lines: got scl=%b sda=%b expected 1 1", scl_a, sda_a);
    end
    checks++;
    if (ready_a !== 1'b1 || nack_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_status: got ready=%b nack=%b expected 1 0", ready_a, nack_a);
    end
    checks++;
    if (stops != 0) begin
      errors++;
      $display("FAIL midrst_no_stop: got %0d stops expected 0", stops);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_frame(1'b0, 8'h10, 16'h0100, 8'h01, 0, 0, 1'b0);
    model(1'b0, 8'h10, 16'h0100, 8'h01, 0, 0);
    checks++;
    if (obs_lat != exp_lat || obs_bytes.size() != 4 || obs_bytes[3] !== exp_q[3]) begin
      errors++;
      $display("FAIL midrst_clean_frame: got lat=%0d bytes=%0d expected %0d 4",
               obs_lat, obs_bytes.size(), exp_lat);
    end
  endtask

  task automatic test_div4();
    do_frame(1'b1, 8'h10, 16'h0100, 8'hA5, 0, 0, 1'b0);
    model(1'b1, 8'h10, 16'h0100, 8'hA5, 0, 0);
    checks++;
    if (obs_lat != exp_lat) begin
      errors++;
      $display("FAIL div4_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    checks++;
    if (obs_bytes.size() != 4) begin
      errors++;
      $display("FAIL div4_nbytes: got %0d expected 4", obs_bytes.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_bytes[i] !== exp_q[i] || obs_acks[i] !== 1'b0) begin
          errors++;
          $display("FAIL div4_byte%0d: got %h ack=%b expected %h ack=0",
                   i, obs_bytes[i], obs_acks[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, d;
    logic [15:0] r;
    int nk;
    for (int it = 0; it < 6; it++) begin
      a  = 8'($urandom_range(0, 255));
      r  = 16'($urandom_range(0, 65535));
      d  = 8'($urandom_range(0, 255));
      nk = $urandom_range(0, 4);
      do_frame(1'b0, a, r, d, nk, 0, 1'b0);
      model(1'b0, a, r, d, nk, 0);
      checks++;
      if (obs_lat != exp_lat || obs_nack !== (nk != 0)) begin
        errors++;
        $display("FAIL rand%0d_timing: got lat=%0d nack=%b expected %0d %b",
                 it, obs_lat, obs_nack, exp_lat, (nk != 0));
      end
      checks++;
      if (obs_bytes.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_nbytes: got %0d expected %0d", it, obs_bytes.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_bytes[i] !== exp_q[i] || obs_acks[i] !== ((i + 1) == nk)) begin
            errors++;
            $display("FAIL rand%0d_byte%0d: got %h ack=%b expected %h ack=%b",
                     it, i, obs_bytes[i], obs_acks[i], exp_q[i], ((i + 1) == nk));
          end
        end
      end
    end
  endtask

`ifdef CAM_I2C_CLKSTRETCH_EN
  task automatic test_stretch();
    do_frame(1'b0, 8'h10, 16'h0100, 8'h01, 0, 0, 1'b1);
    model(1'b0, 8'h10, 16'h0100, 8'h01, 0, 10);
    checks++;
    if (obs_lat != exp_lat) begin
      errors++;
      $display("FAIL stretch_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    checks++;
    if (obs_bytes.size() != 4 || obs_bytes[1] !== exp_q[1] || obs_bytes[3] !== exp_q[3]) begin
      errors++;
      $display("FAIL stretch_data: got %0d bytes expected 4 unchanged", obs_bytes.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_write();
    test_nack_addr();
    test_busy_ignore();
    test_mid_reset();
    test_div4();
    test_random();
`ifdef CAM_I2C_CLKSTRETCH_EN
    test_stretch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
